// File: rtl/cpu_pkg.sv
// Shared types and sizes for the CPU register-file write path.
// Results travel as wb_entry_t; wb_src_t names the two result producers.
package cpu_pkg;

  localparam int DATA_W        = 16;
  localparam int ADDR_W        = 4;
  localparam int NREGS         = 1 << ADDR_W;
  localparam int WB_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_t;

  function automatic wb_src_t other_src(input wb_src_t s);
    return (s == SRC_ALU) ? SRC_LSU : SRC_ALU;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-write / one-read circular queue of writeback entries; head is combinational from storage.
// Caller guarantees space (no overflow check) and only asserts wr1_en together with wr0_en.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr0_en,
  input  wb_entry_t     wr0_dat,
  input  logic          wr1_en,
  input  wb_entry_t     wr1_dat,
  input  logic          rd_en,
  output wb_entry_t     head,
  output logic [CW-1:0] count
);

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     hd_ptr;
  logic [PW-1:0]     tl_ptr;

  // Storage is not reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[tl_ptr] <= wr0_dat;
    if (wr1_en) mem[tl_ptr + PW'(wr0_en)] <= wr1_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_ptr <= '0;
      tl_ptr <= '0;
      count  <= '0;
    end else begin
      tl_ptr <= tl_ptr + PW'(wr0_en) + PW'(wr1_en);
      hd_ptr <= hd_ptr + PW'(rd_en);
      count  <= count + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
    end
  end

  assign head = mem[hd_ptr];

endmodule

// File: rtl/reg_writeback.sv
// Merges ALU/LSU results into a queue and retires one regfile write per cycle; tracks pending writes.
// Handshake to wen takes two edges on an empty queue; readies come from registered occupancy only.
module reg_writeback
  import cpu_pkg::*;
#(
  parameter  int FIFO_DEPTH = WB_FIFO_DEPTH,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              wen,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] wdata,
  output logic [NREGS-1:0]  busy,
  output logic [CNT_W-1:0]  fifo_count
);

  wb_src_t          rr_ptr;
  logic [CNT_W-1:0] free;
  logic             alu_push, lsu_push, fav_push, pop;
  wb_entry_t        alu_ent, lsu_ent, wr0_dat, wr1_dat, head;
  logic             wr0_en, wr1_en;
  logic [NREGS-1:0] busy_nxt;

  assign free      = CNT_W'(FIFO_DEPTH) - fifo_count;
  // With a single free slot only the favoured source may push, whether or not it is valid.
  assign alu_ready = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && (rr_ptr == SRC_ALU));
  assign lsu_ready = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && (rr_ptr == SRC_LSU));
  assign alu_push  = alu_valid && alu_ready;
  assign lsu_push  = lsu_valid && lsu_ready;
  assign fav_push  = (rr_ptr == SRC_ALU) ? alu_push : lsu_push;
  assign pop       = (fifo_count != '0);

  assign alu_ent = '{rd: alu_rd, data: alu_data};
  assign lsu_ent = '{rd: lsu_rd, data: lsu_data};

  always_comb begin
    wr0_en = alu_push || lsu_push;
    wr1_en = alu_push && lsu_push;
    if (rr_ptr == SRC_ALU) begin
      wr0_dat = alu_push ? alu_ent : lsu_ent;
      wr1_dat = lsu_ent;
    end else begin
      wr0_dat = lsu_push ? lsu_ent : alu_ent;
      wr1_dat = alu_ent;
    end
  end

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr0_en  (wr0_en),
    .wr0_dat (wr0_dat),
    .wr1_en  (wr1_en),
    .wr1_dat (wr1_dat),
    .rd_en   (pop),
    .head    (head),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= SRC_ALU;
    end else if (fav_push) begin
      rr_ptr <= other_src(rr_ptr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen   <= 1'b0;
      rd    <= '0;
      wdata <= '0;
    end else begin
      wen <= pop;
      if (pop) begin
        rd    <= head.rd;
        wdata <= head.data;
      end
    end
  end

  // Issue is applied after commit so a same-cycle set of the committing register wins.
  always_comb begin
    busy_nxt = busy;
    if (wen)       busy_nxt[rd]     = 1'b0;
    if (iss_valid) busy_nxt[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

`ifndef SYNTHESIS
  a_waw: assert property (@(posedge clk) disable iff (!rst_n)
    iss_valid |-> (!busy[iss_rd] || (wen && (rd == iss_rd))));
  a_alu_busy: assert property (@(posedge clk) disable iff (!rst_n)
    alu_push |-> busy[alu_rd]);
  a_lsu_busy: assert property (@(posedge clk) disable iff (!rst_n)
    lsu_push |-> busy[lsu_rd]);
  a_alu_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (alu_valid && !alu_ready) |=> (alu_valid && $stable(alu_rd) && $stable(alu_data)));
  a_lsu_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (lsu_valid && !lsu_ready) |=> (lsu_valid && $stable(lsu_rd) && $stable(lsu_data)));
  a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= CNT_W'(FIFO_DEPTH));
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed scenarios plus random traffic, checked every cycle against a queue-based reference model.
module tb_reg_writeback;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, alu_valid, lsu_valid;
  logic [3:0]  iss_rd, alu_rd, lsu_rd;
  logic [15:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, wen;
  logic [3:0]  rd;
  logic [15:0] wdata, busy;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  reg_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wen(wen), .rd(rd), .wdata(wdata), .busy(busy), .fifo_count(fifo_count)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: queue of pending writes, favoured-source bit, expected outputs.
  typedef struct {
    logic [3:0]  rd;
    logic [15:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          m_rr;      // 0: ALU favoured, 1: LSU favoured
  bit          m_wen;
  logic [3:0]  m_rd;
  logic [15:0] m_wdata;
  logic [15:0] m_busy;
  int          owed[$];
  bit          last_ap, last_lp;

  task automatic model_reset();
    mq.delete();
    owed.delete();
    m_rr = 0; m_wen = 0; m_rd = '0; m_wdata = '0; m_busy = '0;
  endtask

  task automatic idle_inputs();
    iss_valid = 0; alu_valid = 0; lsu_valid = 0;
    iss_rd = '0; alu_rd = '0; lsu_rd = '0; alu_data = '0; lsu_data = '0;
  endtask

  // One clock: check readies, advance the model across the edge, check registered outputs.
  task automatic step();
    int   free;
    bit   er_a, er_l, ap, lp;
    ent_t ea, el, e;
    #1;
    free = 4 - mq.size();
    er_a = (free >= 2) || (free == 1 && !m_rr);
    er_l = (free >= 2) || (free == 1 && m_rr);
    chk("alu_ready", alu_ready, er_a);
    chk("lsu_ready", lsu_ready, er_l);
    ap = alu_valid && er_a;
    lp = lsu_valid && er_l;
    ea.rd = alu_rd; ea.data = alu_data;
    el.rd = lsu_rd; el.data = lsu_data;
    if (m_wen) m_busy[m_rd] = 1'b0;
    if (iss_valid) m_busy[iss_rd] = 1'b1;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_wen = 1; m_rd = e.rd; m_wdata = e.data;
    end else begin
      m_wen = 0;
    end
    if (!m_rr) begin
      if (ap) mq.push_back(ea);
      if (lp) mq.push_back(el);
      if (ap) m_rr = 1;
    end else begin
      if (lp) mq.push_back(el);
      if (ap) mq.push_back(ea);
      if (lp) m_rr = 0;
    end
    @(posedge clk); #1;
    chk("wen", wen, m_wen);
    chk("rd", rd, m_rd);
    chk("wdata", wdata, m_wdata);
    chk("busy", busy, m_busy);
    chk("fifo_count", fifo_count, mq.size());
    last_ap = ap;
    last_lp = lp;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [3:0] r);
    iss_valid = 1; iss_rd = r;
    step();
    iss_valid = 0;
  endtask

  logic [3:0] sat_a [6];
  logic [3:0] sat_l [6];

  initial begin
    int ai, li, r, idx;
    rst_n = 1'b1;
    idle_inputs();
    #1;
    // 1: reset
    do_reset();
    #1;
    chk("rst_wen", wen, 0);
    chk("rst_busy", busy, 16'h0000);
    chk("rst_count", fifo_count, 0);
    chk("rst_alu_rdy", alu_ready, 1);
    chk("rst_lsu_rdy", lsu_ready, 1);

    // 2: single write
    issue(4'd3);
    alu_valid = 1; alu_rd = 4'd3; alu_data = 16'hBEEF;
    step();
    alu_valid = 0;
    step();
    chk("t2_wen", wen, 1);
    chk("t2_rd", rd, 3);
    chk("t2_wdata", wdata, 16'hBEEF);
    chk("t2_busy_held", busy[3], 1);
    step();
    chk("t2_busy_clr", busy[3], 0);

    // 3: dual push with ALU favoured
    do_reset();
    issue(4'd1);
    issue(4'd2);
    alu_valid = 1; alu_rd = 4'd1; alu_data = 16'h1111;
    lsu_valid = 1; lsu_rd = 4'd2; lsu_data = 16'h2222;
    step();
    chk("t3_count", fifo_count, 2);
    alu_valid = 0; lsu_valid = 0;
    step();
    chk("t3_first", {wen, rd, wdata}, {1'b1, 4'd1, 16'h1111});
    step();
    chk("t3_second", {wen, rd, wdata}, {1'b1, 4'd2, 16'h2222});
    step();

    // 4: saturation, both sources valid every cycle
    for (int i = 0; i < 6; i++) begin
      sat_a[i] = 4'(4 + 2 * i);
      sat_l[i] = 4'(5 + 2 * i);
    end
    for (int i = 4; i < 16; i++) issue(4'(i));
    ai = 0; li = 0;
    for (int c = 0; c < 40 && (ai < 6 || li < 6); c++) begin
      alu_valid = (ai < 6); alu_rd = sat_a[ai % 6]; alu_data = 16'hA000 + 16'(ai);
      lsu_valid = (li < 6); lsu_rd = sat_l[li % 6]; lsu_data = 16'h5000 + 16'(li);
      step();
      if (alu_valid && last_ap) ai++;
      if (lsu_valid && last_lp) li++;
    end
    chk("t4_all_accepted", ai + li, 12);
    idle_inputs();
    repeat (6) step();
    chk("t4_drained", busy, 16'h0000);

    // 5: set/clear collision on r5
    issue(4'd5);
    alu_valid = 1; alu_rd = 4'd5; alu_data = 16'h0555;
    step();
    alu_valid = 0;
    step();
    chk("t5_commit", {wen, rd}, {1'b1, 4'd5});
    iss_valid = 1; iss_rd = 4'd5;
    step();
    iss_valid = 0;
    chk("t5_set_wins", busy[5], 1);
    lsu_valid = 1; lsu_rd = 4'd5; lsu_data = 16'h5555;
    step();
    lsu_valid = 0;
    repeat (3) step();
    chk("t5_clear", busy[5], 0);

    // 6: reset in the middle of traffic
    for (int i = 6; i < 10; i++) issue(4'(i));
    alu_valid = 1; alu_rd = 4'd6; alu_data = 16'h6666;
    lsu_valid = 1; lsu_rd = 4'd7; lsu_data = 16'h7777;
    step();
    alu_rd = 4'd8; alu_data = 16'h8888;
    lsu_rd = 4'd9; lsu_data = 16'h9999;
    step();
    chk("t6_queued", {wen, fifo_count}, {1'b1, 3'd3});
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_wen_async", wen, 0);
    chk("t6_count_async", fifo_count, 0);
    chk("t6_busy_async", busy, 16'h0000);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    chk("t6_no_stale", wen, 0);

    // Random traffic obeying the decode/producer protocol
    for (int c = 0; c < 600; c++) begin
      iss_valid = 0;
      if ($urandom_range(1, 0) == 1) begin
        r = $urandom_range(15, 0);
        if (!m_busy[r]) begin
          iss_valid = 1; iss_rd = 4'(r);
        end
      end
      step();
      if (iss_valid) owed.push_back(int'(iss_rd));
      iss_valid = 0;
      if (alu_valid && last_ap) alu_valid = 0;
      if (lsu_valid && last_lp) lsu_valid = 0;
      if (!alu_valid && owed.size() > 0 && $urandom_range(2, 0) != 0) begin
        idx = $urandom_range(owed.size() - 1, 0);
        alu_rd = 4'(owed[idx]); alu_data = 16'($urandom); alu_valid = 1;
        owed.delete(idx);
      end
      if (!lsu_valid && owed.size() > 0 && $urandom_range(2, 0) != 0) begin
        idx = $urandom_range(owed.size() - 1, 0);
        lsu_rd = 4'(owed[idx]); lsu_data = 16'($urandom); lsu_valid = 1;
        owed.delete(idx);
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
